operand_sweep_checker: RTL

- Synthesizable exhaustive-stimulus sequencer and self-checker for small combinational or pipelined blocks with several equal-width operands and a 1-bit result.
- Drives all operand combinations (full cartesian) or a per-operand walk onto the DUT.
- Compares DUT output against a golden-model output after a fixed pipeline latency, and counts mismatches.
- Used in benches and on-chip BIST wrappers around 4-bit datapath blocks.

---
 rtl/operand_sweep_checker.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/operand_sweep_checker.sv
// Exhaustive operand sequencer + result checker: full cartesian or per-operand walk sweep,
// latency-aligned dut_y/exp_y compare, saturating error count. Optional SWEEP_FIRST_ERR_EN adds first-mismatch capture.
module operand_sweep_checker #(
  parameter int WIDTH     = 4,
  parameter int NUM_OPS   = 3,
  parameter int LATENCY   = 1,
  parameter int ERR_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mode,
  input  logic                       hold,
  output logic [NUM_OPS*WIDTH-1:0]   ops_out,
  output logic                       vec_valid,
  input  logic                       dut_y,
  input  logic                       exp_y,
  output logic                       busy,
  output logic                       done,
  output logic [ERR_CNT_W-1:0]       err_cnt
`ifdef SWEEP_FIRST_ERR_EN
  ,
  output logic [NUM_OPS*WIDTH-1:0]   first_err_vec,
  output logic                       first_err_valid
`endif
);
  localparam int OPW     = NUM_OPS * WIDTH;
  localparam int PH_W    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int DR_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DR_INIT = (LATENCY > 0) ? LATENCY - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e           state_q;
  logic [OPW-1:0]   ops_q, cnt_q, walk_vec, cur_vec;
  logic [WIDTH-1:0] walk_q;
  logic [PH_W-1:0]  phase_q;
  logic [DR_W-1:0]  drain_q;
  logic             vld_q, busy_q, done_q, mode_q, last_q, cur_last;
  logic [ERR_CNT_W-1:0] err_q;
  logic             start_ok, dly_vld, mism;

  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    walk_vec = '0;
    for (int k = 0; k < NUM_OPS; k++)
      if (phase_q == PH_W'(k)) walk_vec[k*WIDTH +: WIDTH] = walk_q;
  end

  // Terminal detection on all-ones so a counter as wide as the vector never overflows.
  always_comb begin
    cur_vec  = mode_q ? walk_vec : cnt_q;
    cur_last = mode_q ? ((&walk_q) && (phase_q == PH_W'(NUM_OPS - 1))) : (&cnt_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ops_q   <= '0;
      cnt_q   <= '0;
      walk_q  <= '0;
      phase_q <= '0;
      drain_q <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          mode_q  <= mode;
          ops_q   <= '0;
          cnt_q   <= '0;
          walk_q  <= '0;
          phase_q <= '0;
          last_q  <= 1'b0;
        end
        S_RUN: begin
          // last_q means the final vector sat on the bus last cycle; leave RUN now.
          if (last_q) begin
            vld_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
              drain_q <= DR_W'(DR_INIT);
            end
          end else if (hold) begin
            vld_q <= 1'b0;
          end else begin
            vld_q  <= 1'b1;
            ops_q  <= cur_vec;
            last_q <= cur_last;
            cnt_q  <= cnt_q + 1'b1;
            walk_q <= walk_q + 1'b1;
            if (&walk_q) phase_q <= phase_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SWEEP_FIRST_ERR_EN
  logic [OPW-1:0] dly_ops;
`endif

  generate
    if (LATENCY == 0) begin : g_nodly
      assign dly_vld = vld_q;
`ifdef SWEEP_FIRST_ERR_EN
      assign dly_ops = ops_q;
`endif
    end else begin : g_dly
      logic [LATENCY-1:0] vld_pipe_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_pipe_q <= '0;
        else begin
          vld_pipe_q[0] <= vld_q;
          for (int i = 1; i < LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
      end
      assign dly_vld = vld_pipe_q[LATENCY-1];
`ifdef SWEEP_FIRST_ERR_EN
      logic [LATENCY-1:0][OPW-1:0] ops_pipe_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) ops_pipe_q <= '0;
        else begin
          ops_pipe_q[0] <= ops_q;
          for (int i = 1; i < LATENCY; i++) ops_pipe_q[i] <= ops_pipe_q[i-1];
        end
      end
      assign dly_ops = ops_pipe_q[LATENCY-1];
`endif
    end
  endgenerate

  assign mism = dly_vld && (dut_y != exp_y);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  err_q <= '0;
    else if (start_ok)          err_q <= '0;
    else if (mism && !(&err_q)) err_q <= err_q + 1'b1;
  end

`ifdef SWEEP_FIRST_ERR_EN
  logic [OPW-1:0] fe_vec_q;
  logic           fe_vld_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fe_vec_q <= '0;
      fe_vld_q <= 1'b0;
    end else if (start_ok) begin
      fe_vec_q <= '0;
      fe_vld_q <= 1'b0;
    end else if (mism && !fe_vld_q) begin
      fe_vec_q <= dly_ops;
      fe_vld_q <= 1'b1;
    end
  end
  assign first_err_vec   = fe_vec_q;
  assign first_err_valid = fe_vld_q;
`endif

  assign ops_out   = ops_q;
  assign vec_valid = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_cnt   = err_q;
endmodule
